// File: rtl/lut_logic_gate_seq.sv
// Reconfigurable N-input lookup-table gate: registered inputs, debounced output,
// and a serial MSB-first truth-table reload through a small handshake FSM.
module lut_logic_gate_seq #(
  parameter int                  N_IN     = 3,
  parameter logic [2**N_IN-1:0]  TT_RESET = 8'hC7,
  parameter int                  DEBOUNCE = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_IN-1:0]      in_i,
  output logic                 out_o,
  output logic                 out_changed_o,
  input  logic                 cfg_start_i,
  input  logic                 cfg_valid_i,
  input  logic                 cfg_bit_i,
  output logic                 cfg_ready_o,
  output logic                 cfg_done_o,
  output logic [2**N_IN-1:0]   tt_active_o
);

  localparam int TT_W  = 2**N_IN;
  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);
  localparam logic [N_IN-1:0]  BC_MAX  = N_IN'(TT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } cfg_state_e;

  cfg_state_e        state_q, state_d;
  logic [N_IN-1:0]   in_q;
  logic [N_IN-1:0]   bc_q, bc_d;
  logic [TT_W-1:0]   shadow_q, shadow_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_q, out_d;
  logic              chg_q, chg_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [N_IN-1:0]   idx_s;
  logic              raw_s;

  // Index 0 maps to the table MSB, so the bit position is the complement of the index.
  always_comb begin
    idx_s = ~in_q;
    raw_s = tt_q[idx_s];
  end

  // Debounce: raw must differ from out for DEBOUNCE consecutive cycles.
  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q;
    chg_d = 1'b0;
    if (raw_s == out_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_MAX) begin
      out_d = raw_s;
      cnt_d = {CNT_W{1'b0}};
      chg_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Table-load FSM: shadow fills while the old table keeps evaluating.
  always_comb begin
    state_d  = state_q;
    bc_d     = bc_q;
    shadow_d = shadow_q;
    tt_d     = tt_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start_i) begin
          state_d  = ST_LOAD;
          bc_d     = {N_IN{1'b0}};
          shadow_d = {TT_W{1'b0}};
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cfg_start_i) begin
          bc_d     = {N_IN{1'b0}};
          shadow_d = {TT_W{1'b0}};
        end else if (cfg_valid_i) begin
          shadow_d = {shadow_q[TT_W-2:0], cfg_bit_i};
          bc_d     = bc_q + N_IN'(1);
          if (bc_q == BC_MAX) begin
            state_d = ST_COMMIT;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d  = ST_LOAD;
        end
      end
      ST_COMMIT: begin
        tt_d    = shadow_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_LOAD);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      in_q     <= {N_IN{1'b0}};
      bc_q     <= {N_IN{1'b0}};
      shadow_q <= {TT_W{1'b0}};
      tt_q     <= TT_RESET;
      cnt_q    <= {CNT_W{1'b0}};
      out_q    <= 1'b0;
      chg_q    <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_q     <= in_i;
      bc_q     <= bc_d;
      shadow_q <= shadow_d;
      tt_q     <= tt_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      chg_q    <= chg_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign out_o         = out_q;
  assign out_changed_o = chg_q;
  assign cfg_ready_o   = ready_q;
  assign cfg_done_o    = done_q;
  assign tt_active_o   = tt_q;

endmodule

// File: tb/tb_lut_logic_gate_seq.sv
// Directed bench for lut_logic_gate_seq: default 3-input instance plus a
// 1-input inverter instance with single-cycle debounce.
module tb_lut_logic_gate_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in;
  logic       cfg_start, cfg_valid, cfg_bit;
  logic       out, out_changed, cfg_ready, cfg_done;
  logic [7:0] tt_active;

  logic [0:0] in2;
  logic       zero2;
  logic       out2, chg2, ready2, done2;
  logic [1:0] tt2;

  int checks   = 0;
  int failures = 0;

  bit sweep_exp [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic prev;

  always #5 clk = ~clk;

  lut_logic_gate_seq #(.N_IN(3), .TT_RESET(8'hC7), .DEBOUNCE(2)) dut (
    .clk_i(clk), .rst_i(rst), .in_i(in), .out_o(out), .out_changed_o(out_changed),
    .cfg_start_i(cfg_start), .cfg_valid_i(cfg_valid), .cfg_bit_i(cfg_bit),
    .cfg_ready_o(cfg_ready), .cfg_done_o(cfg_done), .tt_active_o(tt_active)
  );

  lut_logic_gate_seq #(.N_IN(1), .TT_RESET(2'b10), .DEBOUNCE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_i(in2), .out_o(out2), .out_changed_o(chg2),
    .cfg_start_i(zero2), .cfg_valid_i(zero2), .cfg_bit_i(zero2),
    .cfg_ready_o(ready2), .cfg_done_o(done2), .tt_active_o(tt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    cfg_valid = 1'b1;
    cfg_bit   = b;
    tick();
    cfg_valid = 1'b0;
    chk("no_early_done", {63'd0, cfg_done}, 64'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in = 3'd0; in2 = 1'b0; zero2 = 1'b0;
    cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    tick(); tick();
    chk("rst_out", {63'd0, out}, 64'd0);
    chk("rst_chg", {63'd0, out_changed}, 64'd0);
    chk("rst_ready", {63'd0, cfg_ready}, 64'd0);
    chk("rst_done", {63'd0, cfg_done}, 64'd0);
    chk("rst_tt", {56'd0, tt_active}, 64'hC7);
    chk("rst_out2", {63'd0, out2}, 64'd0);
    chk("rst_tt2", {62'd0, tt2}, 64'h2);
    rst = 1'b0;

    // N_IN=1 inverter with DEBOUNCE=1
    tick();
    chk("inv_first", {63'd0, out2}, 64'd1);
    chk("inv_first_chg", {63'd0, chg2}, 64'd1);
    chk("main_settling", {63'd0, out}, 64'd0);
    tick();
    chk("main_settled", {63'd0, out}, 64'd1);
    chk("main_settled_chg", {63'd0, out_changed}, 64'd1);
    chk("inv_chg_clear", {63'd0, chg2}, 64'd0);
    in2 = 1'b1;
    tick();
    chk("inv_hold", {63'd0, out2}, 64'd1);
    tick();
    chk("inv_in1", {63'd0, out2}, 64'd0);
    chk("inv_in1_chg", {63'd0, chg2}, 64'd1);
    in2 = 1'b0;
    tick(); tick();
    chk("inv_in0", {63'd0, out2}, 64'd1);

    // Sweep all indices against table C7
    prev = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in = 3'(i);
      tick(); tick();
      chk("sweep_hold", {63'd0, out}, {63'd0, prev});
      chk("sweep_hold_chg", {63'd0, out_changed}, 64'd0);
      tick();
      chk("sweep_out", {63'd0, out}, {63'd0, sweep_exp[i]});
      chk("sweep_chg", {63'd0, out_changed}, {63'd0, (sweep_exp[i] != prev)});
      tick();
      chk("sweep_chg_once", {63'd0, out_changed}, 64'd0);
      prev = sweep_exp[i];
    end
    chk("sweep_tt", {56'd0, tt_active}, 64'hC7);

    // Two single-cycle glitches must not leak through
    in = 3'd0;
    repeat (4) tick();
    chk("glitch_pre", {63'd0, out}, 64'd1);
    repeat (2) begin
      in = 3'd2;
      tick();
      in = 3'd0;
      repeat (4) begin
        tick();
        chk("glitch_out", {63'd0, out}, 64'd1);
        chk("glitch_chg", {63'd0, out_changed}, 64'd0);
      end
    end

    // Restart mid-load, then load FF
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("load_ready", {63'd0, cfg_ready}, 64'd1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    in = 3'd2;
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b0;
    tick();
    cfg_start = 1'b0; cfg_valid = 1'b0;
    chk("restart_ready", {63'd0, cfg_ready}, 64'd1);
    tick(); tick();
    chk("load_old_table", {63'd0, out}, 64'd0);
    chk("load_tt_old", {56'd0, tt_active}, 64'hC7);
    repeat (7) send_bit(1'b1);
    cfg_valid = 1'b1; cfg_bit = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("commit_ready", {63'd0, cfg_ready}, 64'd0);
    chk("commit_tt_old", {56'd0, tt_active}, 64'hC7);
    tick();
    chk("ff_done", {63'd0, cfg_done}, 64'd1);
    chk("ff_tt", {56'd0, tt_active}, 64'hFF);
    tick();
    chk("ff_done_pulse", {63'd0, cfg_done}, 64'd0);
    chk("switch_debounce", {63'd0, out}, 64'd0);
    tick();
    chk("switch_out", {63'd0, out}, 64'd1);
    chk("switch_chg", {63'd0, out_changed}, 64'd1);

    // Reload AND3; start with a valid bit that must be ignored
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
    tick();
    cfg_start = 1'b0; cfg_valid = 1'b0;
    repeat (7) send_bit(1'b0);
    cfg_valid = 1'b1; cfg_bit = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("and_commit_ready", {63'd0, cfg_ready}, 64'd0);
    tick();
    chk("and_done", {63'd0, cfg_done}, 64'd1);
    chk("and_tt", {56'd0, tt_active}, 64'h01);
    tick();
    chk("and_done_pulse", {63'd0, cfg_done}, 64'd0);
    tick(); tick();
    chk("and_in2", {63'd0, out}, 64'd0);
    in = 3'd7;
    tick(); tick(); tick();
    chk("and_in7", {63'd0, out}, 64'd1);
    in = 3'd6;
    tick(); tick(); tick();
    chk("and_in6", {63'd0, out}, 64'd0);

    // Reset mid-load
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_tt", {56'd0, tt_active}, 64'hC7);
    chk("mrst_ready", {63'd0, cfg_ready}, 64'd0);
    chk("mrst_out", {63'd0, out}, 64'd0);
    chk("mrst_done", {63'd0, cfg_done}, 64'd0);
    cfg_valid = 1'b1; cfg_bit = 1'b0;
    tick(); tick();
    cfg_valid = 1'b0;
    chk("mrst_idle", {63'd0, cfg_ready}, 64'd0);
    chk("mrst_tt_hold", {56'd0, tt_active}, 64'hC7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lut_logic_gate_seq.md
Name: lut_logic_gate_seq

Overview:
- Parametrised successor to the fixed 3-input truth-table gate modules: one N-input Boolean function whose truth table is a parameter at reset and can be reloaded at run time over a serial handshake.
- Inputs are registered and the output is debounced, so it changes only after the new function value has been stable for a set number of cycles.
- Sits between sensor/input conditioning and downstream circuit-level logic. It replaces per-function combinational modules with one reusable, reconfigurable block.

Parameters:
- N_IN, 3, number of logic inputs (1..6); table size TT_W = 2**N_IN bits.
- TT_RESET, 8'hC7 (TT_W bits), truth table loaded at reset.
- DEBOUNCE, 2, consecutive cycles (>=1) a new function value must persist before out changes.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in  input  N_IN  logic inputs; in[N_IN-1] is in1 (MSB of index), in[0] is inN.
- out  output  1  debounced, registered function output.
- out_changed  output  1  one-cycle pulse on the edge where out toggles.
- cfg_start  input  1  begin (or restart) a table load.
- cfg_valid  input  1  cfg_bit is valid.
- cfg_bit  input  1  serial table bit.
- cfg_ready  output  1  block accepts cfg_bit this cycle.
- cfg_done  output  1  one-cycle pulse when a new table is committed.
- tt_active  output  TT_W  currently active truth table.

Behaviour:
- Table convention: the output for index idx = {in1..inN} is tt[TT_W-1-idx], i.e. index 0 maps to the MSB. With TT_RESET=8'hC7 and N_IN=3: 000,001,101,110,111 give 1; 010,011,100 give 0.
- Reset, applied on a rising edge with rst=1:
  - tt_active=TT_RESET, shadow table=0, in_q=0, out=0, cnt=0.
  - out_changed=0, cfg_ready=0, cfg_done=0, FSM=IDLE.
  - Reset mid-load discards the partial shadow; tt_active returns to TT_RESET.
- Evaluation path, every cycle:
  - in_q <= in.
  - raw = tt_active[TT_W-1-in_q] (combinational).
- Debounce:
  - If raw==out: cnt<=0.
  - Else if cnt==DEBOUNCE-1: out<=raw, cnt<=0, out_changed<=1.
  - Else: cnt<=cnt+1.
  - out_changed is 0 in every other cycle.
  - Any glitch back to out's value clears cnt.
  - Latency: an input change held stable appears on out after DEBOUNCE+1 rising edges (1 sample edge + DEBOUNCE).
  - cnt width is clog2(DEBOUNCE), minimum 1; it never wraps.
- Config FSM:
  - IDLE: cfg_ready=0. cfg_start=1 -> LOAD with bit counter bc=0.
  - LOAD: cfg_ready=1. On cfg_valid & cfg_ready, shift cfg_bit into the shadow MSB-first and set bc<=bc+1. On the accept where bc==TT_W-1 -> COMMIT. cfg_valid=0 stalls with no timeout.
  - LOAD with cfg_start=1: restart, bc<=0, shadow cleared, and any cfg_bit in that cycle is ignored.
  - COMMIT (1 cycle): cfg_ready=0, tt_active<=shadow, cfg_done<=1, -> IDLE. cfg_start in COMMIT is ignored.
- Table switchover:
  - Evaluation continues on the old tt_active throughout LOAD.
  - The new table drives raw from the cycle after COMMIT.
  - The resulting out change is still debounced (DEBOUNCE more edges).
- Simultaneous events: rst overrides everything. cfg_start in IDLE with cfg_valid=1 does not accept a bit that cycle.

Test Plan:
- Reset with N_IN=3, TT_RESET=C7, DEBOUNCE=2, then sweep in over 000..111, holding each for 4 cycles -> out=1,1,0,0,0,1,1,1 and tt_active=C7. out reaches each value 3 edges after in is applied; out_changed pulses once per toggle.
- Glitch: out=1 at in=000, drive in=010 for exactly 1 cycle then back to 000 -> out stays 1, out_changed never pulses.
- Reload: cfg_start, then 8 bits 0,0,0,0,0,0,0,1 (table 8'h01, AND3) with cfg_valid gaps -> cfg_done pulses once and tt_active=01. in=111 gives out=1, in=110 gives out=0.
- Restart mid-load: after 5 bits, pulse cfg_start, then send 8 bits of 8'hFF -> tt_active=FF, not a mix. Before cfg_done, out still follows C7.
- Reset mid-load: after 3 bits assert rst -> tt_active=C7, cfg_ready=0, FSM idle, out=0.
- Parameter sweep N_IN=1, TT_RESET=2'b10, DEBOUNCE=1 -> out=NOT-free buffer inverse (in=0 gives 1, in=1 gives 0) with 2-edge latency.
